// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight predicted branches: up to two pushes and two
// resolves per cycle, drives BHT update strobes and a flush/redirect on mispredict.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid1,
  input  logic                     enq_valid2,
  input  logic [PC_W-1:0]          enq_pc1,
  input  logic [PC_W-1:0]          enq_pc2,
  input  logic                     enq_pred1,
  input  logic                     enq_pred2,
  input  logic [PC_W-1:0]          enq_tgt1,
  input  logic [PC_W-1:0]          enq_tgt2,
  output logic                     enq_ready,
  input  logic                     res_valid1,
  input  logic                     res_valid2,
  input  logic                     res_taken1,
  input  logic                     res_taken2,
  input  logic [PC_W-1:0]          res_tgt1,
  input  logic [PC_W-1:0]          res_tgt2,
  output logic                     branch1,
  output logic                     branch2,
  output logic                     branch_taken1,
  output logic                     branch_taken2,
  output logic [PC_W-1:0]          pcE1,
  output logic [PC_W-1:0]          pcE2,
  output logic                     mispredict,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [PC_W-1:0] tgt_mem  [DEPTH];
  logic            pred_mem [DEPTH];

  logic [AW-1:0]   head, tail, head_nxt1, tail_nxt1;
  logic [PC_W-1:0] e1_pc, e2_pc, e1_tgt, e2_tgt, redirect_nxt;
  logic [PC_W-1:0] push_a_pc, push_a_tgt;
  logic            e1_pred, e2_pred, push_a_pred;
  logic            pop1, pop2, bad1, bad2, flush, issue2;
  logic            push_ok, push_a, push_b;
  logic [1:0]      n_push, n_pop;

  assign enq_ready = (count <= CW'(DEPTH - 2));
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));

  // Resolve decode works from the start-of-cycle occupancy; slot 2 only counts alongside slot 1.
  always_comb begin
    head_nxt1 = head + AW'(1);
    tail_nxt1 = tail + AW'(1);
    e1_pc     = pc_mem[head];
    e1_tgt    = tgt_mem[head];
    e1_pred   = pred_mem[head];
    e2_pc     = pc_mem[head_nxt1];
    e2_tgt    = tgt_mem[head_nxt1];
    e2_pred   = pred_mem[head_nxt1];

    pop1   = res_valid1 && (count != '0);
    pop2   = res_valid1 && res_valid2 && (count >= CW'(2));
    bad1   = pop1 && ((e1_pred != res_taken1) ||
                      (e1_pred && res_taken1 && (e1_tgt != res_tgt1)));
    bad2   = pop2 && !bad1 && ((e2_pred != res_taken2) ||
                               (e2_pred && res_taken2 && (e2_tgt != res_tgt2)));
    issue2 = pop2 && !bad1;
    flush  = bad1 || bad2;

    if (bad1)
      redirect_nxt = res_taken1 ? res_tgt1 : e1_pc + PC_W'(1);
    else
      redirect_nxt = res_taken2 ? res_tgt2 : e2_pc + PC_W'(1);

    push_ok     = enq_ready && !flush;
    push_a      = push_ok && (enq_valid1 || enq_valid2);
    push_b      = push_ok && enq_valid1 && enq_valid2;
    push_a_pc   = enq_valid1 ? enq_pc1   : enq_pc2;
    push_a_tgt  = enq_valid1 ? enq_tgt1  : enq_tgt2;
    push_a_pred = enq_valid1 ? enq_pred1 : enq_pred2;

    n_push = {1'b0, push_a} + {1'b0, push_b};
    n_pop  = {1'b0, pop1} + {1'b0, issue2};
  end

  always_ff @(posedge clk) begin
    if (push_a) begin
      pc_mem[tail]   <= push_a_pc;
      tgt_mem[tail]  <= push_a_tgt;
      pred_mem[tail] <= push_a_pred;
    end
    if (push_b) begin
      pc_mem[tail_nxt1]   <= enq_pc2;
      tgt_mem[tail_nxt1]  <= enq_tgt2;
      pred_mem[tail_nxt1] <= enq_pred2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      branch1       <= 1'b0;
      branch2       <= 1'b0;
      branch_taken1 <= 1'b0;
      branch_taken2 <= 1'b0;
      pcE1          <= '0;
      pcE2          <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
    end else begin
      // A flush discards everything still queued, including this cycle's pushes.
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        head  <= head + AW'(n_pop);
        tail  <= tail + AW'(n_push);
        count <= count + CW'(n_push) - CW'(n_pop);
      end
      branch1    <= pop1;
      branch2    <= issue2;
      mispredict <= flush;
      if (pop1) begin
        branch_taken1 <= res_taken1;
        pcE1          <= e1_pc;
      end
      if (issue2) begin
        branch_taken2 <= res_taken2;
        pcE2          <= e2_pc;
      end
      if (flush)
        redirect_pc <= redirect_nxt;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized scoreboard bench for branch_resolve_queue against a queue-based
// reference model; directed cases cover the documented scenarios first.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 11;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enq_valid1 = 0, enq_valid2 = 0, enq_pred1 = 0, enq_pred2 = 0;
  logic [PC_W-1:0] enq_pc1 = '0, enq_pc2 = '0, enq_tgt1 = '0, enq_tgt2 = '0;
  logic            res_valid1 = 0, res_valid2 = 0, res_taken1 = 0, res_taken2 = 0;
  logic [PC_W-1:0] res_tgt1 = '0, res_tgt2 = '0;
  logic            enq_ready, branch1, branch2, branch_taken1, branch_taken2;
  logic [PC_W-1:0] pcE1, pcE2, redirect_pc;
  logic            mispredict, empty, full;
  logic [3:0]      count;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .enq_valid1(enq_valid1), .enq_valid2(enq_valid2),
    .enq_pc1(enq_pc1), .enq_pc2(enq_pc2),
    .enq_pred1(enq_pred1), .enq_pred2(enq_pred2),
    .enq_tgt1(enq_tgt1), .enq_tgt2(enq_tgt2),
    .enq_ready(enq_ready),
    .res_valid1(res_valid1), .res_valid2(res_valid2),
    .res_taken1(res_taken1), .res_taken2(res_taken2),
    .res_tgt1(res_tgt1), .res_tgt2(res_tgt2),
    .branch1(branch1), .branch2(branch2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .pcE1(pcE1), .pcE2(pcE2),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PC_W-1:0] pc; logic pred; logic [PC_W-1:0] tgt; } ent_t;
  typedef struct {
    logic b1, b2, t1, t2, mis;
    logic [PC_W-1:0] pc1, pc2, redir;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
  endfunction

  function automatic logic wrong(ent_t e, logic taken, logic [PC_W-1:0] tgt);
    return (e.pred != taken) || (e.pred && taken && e.tgt != tgt);
  endfunction

  // One cycle: check start-of-cycle occupancy, drive inputs, advance the reference model.
  task automatic applyStimulus(
    input logic ev1, input logic [PC_W-1:0] p1, input logic pr1, input logic [PC_W-1:0] t1,
    input logic ev2, input logic [PC_W-1:0] p2, input logic pr2, input logic [PC_W-1:0] t2,
    input logic rv1, input logic rt1, input logic [PC_W-1:0] rg1,
    input logic rv2, input logic rt2, input logic [PC_W-1:0] rg2);
    exp_t e;
    int   n;
    logic ready, p1ok, p2ok;
    ent_t ne;
    @(negedge clk);
    n     = mq.size();
    ready = (n <= DEPTH - 2);
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("enq_ready", 32'(enq_ready), 32'(ready));
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("full", 32'(full), 32'(n == DEPTH));
    enq_valid1 = ev1; enq_pc1 = p1; enq_pred1 = pr1; enq_tgt1 = t1;
    enq_valid2 = ev2; enq_pc2 = p2; enq_pred2 = pr2; enq_tgt2 = t2;
    res_valid1 = rv1; res_taken1 = rt1; res_tgt1 = rg1;
    res_valid2 = rv2; res_taken2 = rt2; res_tgt2 = rg2;

    e = '{default: '0};
    p1ok = rv1 && n >= 1;
    p2ok = rv1 && rv2 && n >= 2;
    if (p1ok) begin
      e.b1 = 1; e.t1 = rt1; e.pc1 = mq[0].pc;
      if (wrong(mq[0], rt1, rg1)) begin
        e.mis = 1; e.redir = rt1 ? rg1 : mq[0].pc + 1;
      end else if (p2ok) begin
        e.b2 = 1; e.t2 = rt2; e.pc2 = mq[1].pc;
        if (wrong(mq[1], rt2, rg2)) begin
          e.mis = 1; e.redir = rt2 ? rg2 : mq[1].pc + 1;
        end
      end
      sb.push_back(e);
    end
    if (e.mis) mq.delete();
    else begin
      if (e.b1) void'(mq.pop_front());
      if (e.b2) void'(mq.pop_front());
      if (ready) begin
        if (ev1) begin ne.pc = p1; ne.pred = pr1; ne.tgt = t1; mq.push_back(ne); end
        if (ev2) begin ne.pc = p2; ne.pred = pr2; ne.tgt = t2; mq.push_back(ne); end
      end
    end
  endtask

  task automatic idle();
    applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0);
  endtask

  task automatic push(input logic ev1, input logic [PC_W-1:0] p1, input logic pr1,
                      input logic [PC_W-1:0] t1, input logic ev2, input logic [PC_W-1:0] p2,
                      input logic pr2, input logic [PC_W-1:0] t2);
    applyStimulus(ev1,p1,pr1,t1, ev2,p2,pr2,t2, 0,0,0, 0,0,0);
  endtask

  task automatic resolve(input logic rv1, input logic rt1, input logic [PC_W-1:0] rg1,
                         input logic rv2, input logic rt2, input logic [PC_W-1:0] rg2);
    applyStimulus(0,0,0,0, 0,0,0,0, rv1,rt1,rg1, rv2,rt2,rg2);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an update or flush.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && (branch1 || branch2 || mispredict)) begin
      if (sb.size() == 0) checkOutput("unexpected_output", 32'(1), 32'(0));
      else begin
        e = sb.pop_front();
        checkOutput("branch1", 32'(branch1), 32'(e.b1));
        checkOutput("branch2", 32'(branch2), 32'(e.b2));
        checkOutput("mispredict", 32'(mispredict), 32'(e.mis));
        if (e.b1) begin
          checkOutput("branch_taken1", 32'(branch_taken1), 32'(e.t1));
          checkOutput("pcE1", 32'(pcE1), 32'(e.pc1));
        end
        if (e.b2) begin
          checkOutput("branch_taken2", 32'(branch_taken2), 32'(e.t2));
          checkOutput("pcE2", 32'(pcE2), 32'(e.pc2));
        end
        if (e.mis) checkOutput("redirect_pc", 32'(redirect_pc), 32'(e.redir));
      end
    end
  end

  initial begin
    logic ev1, ev2, pr1, pr2, rv1, rv2, rt1, rt2;
    logic [PC_W-1:0] p1, p2, t1, t2, g1, g2;
    int n;

    repeat (2) @(negedge clk);
    checkOutput("rst_count", 32'(count), 32'(0));
    checkOutput("rst_empty", 32'(empty), 32'(1));
    checkOutput("rst_branch1", 32'(branch1), 32'(0));
    checkOutput("rst_mispredict", 32'(mispredict), 32'(0));
    checkOutput("rst_pcE1", 32'(pcE1), 32'(0));
    checkOutput("rst_redirect", 32'(redirect_pc), 32'(0));
    reset = 1'b1;

    // Single push and correct not-taken resolve.
    push(1,5,0,0, 0,0,0,0);
    resolve(1,0,0, 0,0,0);
    idle();
    // Dual push and dual correct resolve.
    push(1,3,1,20, 1,4,0,0);
    resolve(1,1,20, 1,0,0);
    idle();
    // Entry 1 mispredicts with res_valid2 set: only branch1, queue flushed.
    push(1,1,0,0, 1,2,0,0);
    push(1,3,0,0, 0,0,0,0);
    resolve(1,1,40, 1,0,0);
    idle();
    // Fill to DEPTH-1, dropped push, drain two, then wrap many times.
    push(1,10,0,0, 1,11,0,0);
    push(1,12,0,0, 1,13,0,0);
    push(1,14,0,0, 1,15,0,0);
    push(0,0,0,0, 1,16,0,0);
    push(1,17,0,0, 1,18,0,0);
    resolve(1,0,0, 1,0,0);
    for (int i = 0; i < 20; i++)
      applyStimulus(1,PC_W'(100+2*i),0,0, 1,PC_W'(101+2*i),0,0, 1,0,0, 1,0,0);
    for (int i = 0; i < 5; i++) resolve(1,0,0, 1,0,0);
    // Entry 1 mispredicts while entry 2 at pc=2047 resolves correctly.
    push(1,10,0,0, 1,2047,0,0);
    resolve(1,1,33, 1,0,0);
    // PC wrap on not-taken redirect.
    push(1,2047,1,100, 0,0,0,0);
    resolve(1,0,0, 0,0,0);
    // res_valid2 alone is ignored; entry-2-only mispredict.
    push(1,7,0,0, 1,8,1,50);
    resolve(0,0,0, 1,0,0);
    resolve(1,0,0, 1,1,51);
    idle();

    // Asynchronous reset right while a mispredict pulse is showing.
    push(1,9,0,0, 1,6,0,0);
    resolve(1,1,9, 0,0,0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("async_mispredict", 32'(mispredict), 32'(0));
    checkOutput("async_count", 32'(count), 32'(0));
    checkOutput("async_branch1", 32'(branch1), 32'(0));
    checkOutput("async_redirect", 32'(redirect_pc), 32'(0));
    mq.delete();
    sb.delete();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      n   = mq.size();
      ev1 = 1'($urandom); ev2 = 1'($urandom);
      p1  = PC_W'($urandom); p2 = PC_W'($urandom);
      t1  = PC_W'($urandom); t2 = PC_W'($urandom);
      pr1 = 1'($urandom); pr2 = 1'($urandom);
      rv1 = ($urandom_range(0, 2) != 0); rv2 = 1'($urandom);
      rt1 = 1'($urandom); rt2 = 1'($urandom);
      g1  = PC_W'($urandom); g2 = PC_W'($urandom);
      if (n >= 1) begin
        rt1 = ($urandom_range(0, 11) == 0) ? ~mq[0].pred : mq[0].pred;
        if ($urandom_range(0, 7) != 0) g1 = mq[0].tgt;
      end
      if (n >= 2) begin
        rt2 = ($urandom_range(0, 11) == 0) ? ~mq[1].pred : mq[1].pred;
        if ($urandom_range(0, 7) != 0) g2 = mq[1].tgt;
      end
      applyStimulus(ev1,p1,pr1,t1, ev2,p2,pr2,t2, rv1,rt1,g1, rv2,rt2,g2);
    end
    idle();
    idle();
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
